// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side): decodes MDC/MDIO management frames,
// owns a 32 x 16 register bank and serialises read data back onto MDIO.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd16,
    parameter int unsigned PRE_MIN  = 2,
    parameter bit          BCAST_EN = 1'b0,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
    input  logic        mdc,
    input  logic        rst_n,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        reg_wr_en,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
    } state_e;

    localparam logic [1:0] OP_WR     = 2'b01;
    localparam logic [1:0] OP_RD     = 2'b10;
    localparam logic [5:0] PRE_MIN_W = 6'(PRE_MIN);

    state_e      state_q, state_d;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  phyad_q, phyad_d;
    logic [4:0]  regad_q, regad_d;
    logic        sel_q, sel_d;
    logic [15:0] shift_q, shift_d;
    logic        out_q, out_d, oe_q, oe_d;
    logic        wr_en_q, wr_en_d, err_q, err_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        soft_rst_q, soft_rst_d;
    logic [15:0] regs_q [32];

    logic [4:0]  rd_addr;
    logic [15:0] rd_val;
    logic        addr_match;

    function automatic logic [15:0] reset_val(input logic [4:0] idx);
        case (idx)
            5'd2:    return PHY_ID1;
            5'd3:    return PHY_ID2;
            default: return 16'h0000;
        endcase
    endfunction

    // Read data and selection are resolved at the edge that samples REGAD[0].
    assign rd_addr    = {regad_q[3:0], mdio_in};
    assign rd_val     = (rd_addr == 5'd0) ? {1'b0, regs_q[0][14:0]} : regs_q[rd_addr];
    assign addr_match = (phyad_q == PHY_ADDR) ||
                        (BCAST_EN && (phyad_q == 5'd0) && (op_q == OP_WR));

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        op_d       = op_q;
        phyad_d    = phyad_q;
        regad_d    = regad_q;
        sel_d      = sel_q;
        shift_d    = shift_q;
        out_d      = out_q;
        oe_d       = oe_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        err_d      = 1'b0;
        soft_rst_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mdio_in) begin
                    pre_cnt_d = (pre_cnt_q == 5'd31) ? pre_cnt_q : pre_cnt_q + 5'd1;
                end else begin
                    pre_cnt_d = 5'd0;
                    if ({1'b0, pre_cnt_q} >= PRE_MIN_W) state_d = S_START;
                end
            end
            S_START: begin
                bit_cnt_d = 4'd0;
                if (mdio_in) begin
                    state_d = S_OP;
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_OP: begin
                op_d      = {op_q[0], mdio_in};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd1) begin
                    bit_cnt_d = 4'd0;
                    if (op_d == OP_WR || op_d == OP_RD) begin
                        state_d = S_PHYAD;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_PHYAD: begin
                phyad_d   = {phyad_q[3:0], mdio_in};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd4) begin
                    bit_cnt_d = 4'd0;
                    state_d   = S_REGAD;
                end
            end
            S_REGAD: begin
                regad_d   = rd_addr;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd4) begin
                    bit_cnt_d = 4'd0;
                    state_d   = S_TA;
                    sel_d     = addr_match;
                    shift_d   = rd_val;
                end
            end
            S_TA: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    // Second TA bit of a read is driven low by the responder.
                    oe_d  = sel_q && (op_q == OP_RD);
                    out_d = 1'b0;
                end else begin
                    bit_cnt_d = 4'd0;
                    if (op_q == OP_RD) begin
                        state_d = S_RDATA;
                        out_d   = sel_q & shift_q[15];
                        shift_d = {shift_q[14:0], 1'b0};
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                shift_d   = {shift_q[14:0], mdio_in};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    state_d   = S_IDLE;
                    pre_cnt_d = 5'd0;
                    if (sel_q) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = regad_q;
                        wr_data_d  = shift_d;
                        soft_rst_d = (regad_q == 5'd0) && shift_d[15];
                    end
                end
            end
            S_RDATA: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    state_d   = S_IDLE;
                    pre_cnt_d = 5'd0;
                    oe_d      = 1'b0;
                    out_d     = 1'b0;
                end else begin
                    out_d   = sel_q & shift_q[15];
                    shift_d = {shift_q[14:0], 1'b0};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mdc or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            op_q       <= '0;
            phyad_q    <= '0;
            regad_q    <= '0;
            sel_q      <= 1'b0;
            shift_q    <= '0;
            out_q      <= 1'b0;
            oe_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            soft_rst_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            op_q       <= op_d;
            phyad_q    <= phyad_d;
            regad_q    <= regad_d;
            sel_q      <= sel_d;
            shift_q    <= shift_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            wr_en_q    <= wr_en_d;
            err_q      <= err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            soft_rst_q <= soft_rst_d;
        end
    end

    // NOTE: the bank is reset because software relies on defined reset contents (IDs, zeros).
    always_ff @(posedge mdc or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= reset_val(5'(i));
        end else if (soft_rst_q) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= reset_val(5'(i));
        end else if (wr_en_d && wr_addr_d != 5'd2 && wr_addr_d != 5'd3) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign mdio_out    = out_q;
    assign mdio_oe     = oe_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign frame_err   = err_q;
endmodule
